// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage drives the request side (master); the divider answers (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  start;
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  annul;
  logic                  busy;
  logic                  ready;
  logic [2*DATA_W-1:0]   result;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output busy, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; result = {remainder, quotient} for the HILO write.
// Operands are made non-negative up front and signs are restored on the last step.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        resetn,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dsr_q, dsr_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     trial;
  logic                qbit;
  logic [DATA_W-1:0]   rem_step;
  logic [DATA_W-1:0]   quo_step;

  // Magnitude of a two's-complement operand; passed through unchanged for DIVU.
  // The most negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v,
                                                input logic                     en);
    return (en && v[DATA_W-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Conditional two's-complement negation used for the final sign fix-up.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              en);
    return en ? (~v + 1'b1) : v;
  endfunction

  // One restoring step: shift {rem,dividend} left, trial-subtract the divisor one
  // bit wider than the data so a borrow shows up in the top bit.
  assign shifted  = {rem_q, dvd_q[DATA_W-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  assign qbit     = ~trial[DATA_W];
  assign rem_step = qbit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_step = {dvd_q[DATA_W-2:0], qbit};

  assign bus.ready  = (state_q == S_END) && !bus.annul;
  assign bus.busy   = bus.start && !bus.ready && !bus.annul;
  assign bus.result = result_q;

  // Next-state and datapath update; annul overrides everything except reset.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 != '0) begin
            dvd_d   = abs_val(bus.opdata1, bus.signed_div);
            dsr_d   = abs_val(bus.opdata2, bus.signed_div);
            qneg_d  = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
            rneg_d  = bus.signed_div & bus.opdata1[DATA_W-1];
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_ON;
          end else begin
            state_d = S_DIVZERO;
          end
        end
      end
      S_DIVZERO: begin
        result_d = '0;
        state_d  = S_END;
      end
      S_ON: begin
        rem_d = rem_step;
        dvd_d = quo_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          result_d = {neg_if(rem_step, rneg_q), neg_if(quo_step, qneg_q)};
          state_d  = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (bus.annul) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results, the
// monitor pops one on every ready pulse and checks value and latency.
module tb_div_unit;
  localparam int DW = 32;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.DATA_W(DW)) bus ();

  div_unit #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          t_issue;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] last_res = 64'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division; truncation toward zero, remainder takes
  // the dividend's sign; zero divisor yields 0/0.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit s);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.ready === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready with result %h at cycle %0d, want none",
                 bus.result, cyc);
      end else begin
        e = sbq.pop_front();
        chk64("result", bus.result, e.res);
        chk_int("latency", cyc - e.t_issue, e.lat);
      end
    end
  end

  // Drive a request. lead = edges until the divider samples it in IDLE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input int lead, input bit expect_it, input logic [63:0] want);
    exp_t e;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.signed_div = s;
    bus.start      = 1'b1;
    if (expect_it) begin
      e.res     = want;
      e.t_issue = cyc + lead;
      e.lat     = (b == 32'h0) ? 1 : DW;
      sbq.push_back(e);
      last_res  = want;
    end
  endtask

  // Wait (bounded) for ready; checks stall duration and that busy drops with ready.
  task automatic wait_ready(input int exp_busy);
    int n;
    int busy_n;
    bit seen;
    n = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ready === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: no ready after %0d cycles, want a ready pulse", n);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end else begin
      chk_int("busy_cycles", busy_n, exp_busy);
      chk_int("busy_in_ready", int'(bus.busy), 0);
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [63:0] want);
    @(posedge clk);
    #1;
    issue(a, b, s, 1, 1'b1, want);
    wait_ready((b == 32'h0) ? 2 : DW + 1);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;
    bus.start      = 1'b0;
    bus.annul      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    resetn         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk_int("reset_ready", int'(bus.ready), 0);
    chk64("reset_result", bus.result, 64'h0);

    // Directed cases with hand-derived results.
    do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD});
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000});
    do_div(32'd5, 32'd0, 1'b0, 64'h0);
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF});

    // Annul in the middle of ON: no ready, result untouched.
    @(posedge clk);
    #1;
    issue(32'd20, 32'd3, 1'b0, 1, 1'b0, 64'h0);
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk_int("annul_ready", int'(bus.ready), 0);
    chk64("annul_result_kept", bus.result, last_res);
    repeat (40) @(posedge clk);
    do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3});

    // Annul together with start in IDLE must not launch a division.
    @(posedge clk);
    #1;
    bus.opdata1 = 32'd50;
    bus.opdata2 = 32'd6;
    bus.start   = 1'b1;
    bus.annul   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk64("annul_idle_result", bus.result, last_res);

    // Reset for one edge while ON.
    @(posedge clk);
    #1;
    issue(32'd1000, 32'd7, 1'b0, 1, 1'b0, 64'h0);
    repeat (6) @(posedge clk);
    #1;
    resetn    = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk_int("midrst_ready", int'(bus.ready), 0);
    chk64("midrst_result", bus.result, 64'h0);
    last_res = 64'h0;
    repeat (40) @(posedge clk);
    do_div(32'd1000, 32'd7, 1'b0, {32'd6, 32'd142});

    // Back-to-back: start stays high through the IDLE cycle after ready.
    @(posedge clk);
    #1;
    issue(32'd77, 32'd10, 1'b0, 1, 1'b1, {32'd7, 32'd7});
    wait_ready(DW + 1);
    issue(32'hFFFFFF9C, 32'd9, 1'b1, 2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFF5});
    wait_ready(DW + 1);
    bus.start = 1'b0;

    // Randomized requests against the reference model.
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; rs = 1'b1; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_div(ra, rb, rs, ref_div(ra, rb, rs));
    end

    repeat (5) @(posedge clk);
    chk_int("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

endmodule
